sif_bfly_pair_join: RTL and testbench

SIF_BFLY_PAIR_JOIN -- requirements
Module: sif_bfly_pair_join

---
 rtl/sif_pkg.sv | 15 +
 rtl/sif_sync_fifo.sv | 61 ++++++
 rtl/sif_bfly_pair_join.sv | 93 +++++++++
 tb/tb_sif_bfly_pair_join.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/sif_pkg.sv
// Shared SIF types: fp16 lane and the joined butterfly pair word.
package sif_pkg;

    localparam int FP16_W      = 16;
    localparam int BFLY_PAIR_W = 32;

    typedef logic [FP16_W-1:0]      fp16_t;
    typedef logic [BFLY_PAIR_W-1:0] bfly_pair_t;

    // Difference lane sits in the upper half, sum lane in the lower half.
    function automatic bfly_pair_t pack_pair(input fp16_t m_val, input fp16_t p_val);
        return {m_val, p_val};
    endfunction

endpackage

// File: rtl/sif_sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; head is read straight from registered storage.
module sif_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   occ
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             push_en;
    logic             pop_en;

    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign occ   = wr_ptr_q - rd_ptr_q;
    assign dout  = mem_q[rd_ptr_q[AW-1:0]];

    // A full FIFO refuses a push even when it pops in the same cycle.
    always_comb begin
        push_en  = push & ~full;
        pop_en   = pop & ~empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_en) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_en) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/sif_bfly_pair_join.sv
// Joins the sum (P) and difference (M) fp16 streams into one 32-bit butterfly word with framing.
module sif_bfly_pair_join
    import sif_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int LEN_W = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [LEN_W-1:0]       cfg_len,
    input  logic                   P_vld,
    input  logic [FP16_W-1:0]      P_dat,
    output logic                   P_rdy,
    input  logic                   M_vld,
    input  logic [FP16_W-1:0]      M_dat,
    output logic                   M_rdy,
    output logic                   O_vld,
    output logic [BFLY_PAIR_W-1:0] O_dat,
    input  logic                   O_rdy,
    output logic                   O_last,
    output logic [$clog2(DEPTH):0] P_occ,
    output logic [$clog2(DEPTH):0] M_occ
);

    fp16_t            p_head, m_head;
    logic             p_full, p_empty;
    logic             m_full, m_empty;
    logic             started_q, started_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] eff_len;
    logic             o_fire;

    sif_sync_fifo #(.WIDTH(FP16_W), .DEPTH(DEPTH)) u_p_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (P_vld & P_rdy),
        .din   (P_dat),
        .pop   (o_fire),
        .dout  (p_head),
        .full  (p_full),
        .empty (p_empty),
        .occ   (P_occ)
    );

    sif_sync_fifo #(.WIDTH(FP16_W), .DEPTH(DEPTH)) u_m_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (M_vld & M_rdy),
        .din   (M_dat),
        .pop   (o_fire),
        .dout  (m_head),
        .full  (m_full),
        .empty (m_empty),
        .occ   (M_occ)
    );

    // Ready is held low until the first edge after reset release.
    assign P_rdy  = started_q & ~p_full;
    assign M_rdy  = started_q & ~m_full;
    assign O_vld  = ~p_empty & ~m_empty;
    assign O_dat  = pack_pair(m_head, p_head);
    assign o_fire = O_vld & O_rdy;

    // cfg_len applies live at the first beat of a frame; a zero wraps to 2^LEN_W beats.
    assign eff_len = (cnt_q == '0) ? cfg_len : len_q;
    assign O_last  = O_vld && (cnt_q == (eff_len - LEN_W'(1)));

    always_comb begin
        started_d = 1'b1;
        cnt_d     = cnt_q;
        len_d     = len_q;
        if (!started_q || (o_fire && (cnt_q == '0))) begin
            len_d = cfg_len;
        end
        if (o_fire) begin
            cnt_d = O_last ? '0 : cnt_q + LEN_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started_q <= 1'b0;
            cnt_q     <= '0;
            len_q     <= '0;
        end else begin
            started_q <= started_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
        end
    end

endmodule

// File: tb/tb_sif_bfly_pair_join.sv
// Scoreboard bench for sif_bfly_pair_join: per-stream queues, frame model, directed and random phases.
module tb_sif_bfly_pair_join;

    localparam int DEPTH = 4;
    localparam int LEN_W = 10;
    localparam int OCC_W = $clog2(DEPTH) + 1;

    logic             clk;
    logic             rst_n;
    logic [LEN_W-1:0] cfg_len;
    logic             P_vld;
    logic [15:0]      P_dat;
    logic             P_rdy;
    logic             M_vld;
    logic [15:0]      M_dat;
    logic             M_rdy;
    logic             O_vld;
    logic [31:0]      O_dat;
    logic             O_rdy;
    logic             O_last;
    logic [OCC_W-1:0] P_occ;
    logic [OCC_W-1:0] M_occ;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [15:0] pq[$];
    logic [15:0] mq[$];
    logic [15:0] p_cur, m_cur;
    bit          rand_data;
    int          exp_cnt, exp_len;
    int          out_beats, last_seen, last_beat_idx;
    int          p_count, m_count;

    sif_bfly_pair_join #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .cfg_len (cfg_len),
        .P_vld   (P_vld),
        .P_dat   (P_dat),
        .P_rdy   (P_rdy),
        .M_vld   (M_vld),
        .M_dat   (M_dat),
        .M_rdy   (M_rdy),
        .O_vld   (O_vld),
        .O_dat   (O_dat),
        .O_rdy   (O_rdy),
        .O_last  (O_last),
        .P_occ   (P_occ),
        .M_occ   (M_occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int cfgBeats();
        return (cfg_len == '0) ? (1 << LEN_W) : int'(cfg_len);
    endfunction

    // One cycle: drive at negedge, observe handshakes that complete at the next posedge.
    task automatic applyStimulus(input bit p_en, input bit m_en, input bit o_en);
        logic [15:0] ph, mh;
        bit          exp_last;
        int          eff;
        @(negedge clk);
        P_vld = p_en;
        P_dat = p_cur;
        M_vld = m_en;
        M_dat = m_cur;
        O_rdy = o_en;
        #1;
        if (O_vld && O_rdy) begin
            checkOutput("sb_nonempty", 64'(pq.size() != 0 && mq.size() != 0), 1);
            if (pq.size() != 0 && mq.size() != 0) begin
                ph  = pq.pop_front();
                mh  = mq.pop_front();
                eff = (exp_cnt == 0) ? cfgBeats() : exp_len;
                if (exp_cnt == 0) exp_len = eff;
                exp_last = (exp_cnt + 1 == eff);
                exp_cnt  = exp_last ? 0 : exp_cnt + 1;
                checkOutput("o_dat", O_dat, {mh, ph});
                checkOutput("o_last", O_last, exp_last);
            end
            out_beats++;
            if (O_last) begin
                last_seen++;
                last_beat_idx = out_beats;
            end
        end
        if (P_vld && P_rdy) begin
            pq.push_back(p_cur);
            p_count++;
            p_cur = rand_data ? 16'($urandom) : p_cur + 16'h1;
        end
        if (M_vld && M_rdy) begin
            mq.push_back(m_cur);
            m_count++;
            m_cur = rand_data ? 16'($urandom) : m_cur + 16'h1;
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        P_vld = 1'b0;
        M_vld = 1'b0;
        O_rdy = 1'b0;
        #1;
        checkOutput("rst_o_vld", O_vld, 0);
        checkOutput("rst_o_last", O_last, 0);
        checkOutput("rst_p_rdy", P_rdy, 0);
        checkOutput("rst_m_rdy", M_rdy, 0);
        checkOutput("rst_p_occ", P_occ, 0);
        checkOutput("rst_m_occ", M_occ, 0);
        pq.delete();
        mq.delete();
        exp_cnt = 0;
        exp_len = 0;
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, 0, 0);
        checkOutput("rdy_rise_p", P_rdy, 1);
        checkOutput("rdy_rise_m", M_rdy, 1);
    endtask

    initial begin
        int base_beats, base_last;
        logic [31:0] head;
        rst_n = 1'b0;
        cfg_len = 10'd1;
        P_vld = 1'b0; P_dat = '0;
        M_vld = 1'b0; M_dat = '0;
        O_rdy = 1'b0;
        p_cur = '0; m_cur = '0;
        rand_data = 1'b0;
        exp_cnt = 0; exp_len = 0;
        out_beats = 0; last_seen = 0; last_beat_idx = 0;
        p_count = 0; m_count = 0;
        repeat (2) @(negedge clk);
        doReset();

        // Lock-step single beat, one-cycle latency.
        p_cur = 16'h3C00;
        m_cur = 16'h4000;
        base_beats = out_beats;
        applyStimulus(1, 1, 1);
        checkOutput("ls_not_yet", O_vld, 0);
        applyStimulus(0, 0, 1);
        checkOutput("ls_latency", out_beats - base_beats, 1);

        // Skew: P runs four beats ahead, M catches up.
        p_cur = 16'h0001;
        m_cur = 16'h0011;
        repeat (4) applyStimulus(1, 0, 1);
        applyStimulus(0, 0, 1);
        checkOutput("skew_p_rdy", P_rdy, 0);
        checkOutput("skew_m_rdy", M_rdy, 1);
        checkOutput("skew_o_vld", O_vld, 0);
        checkOutput("skew_p_occ", P_occ, 4);
        base_beats = out_beats;
        repeat (4) applyStimulus(0, 1, 1);
        repeat (3) applyStimulus(0, 0, 1);
        checkOutput("skew_beats", out_beats - base_beats, 4);

        // Output backpressure with both inputs pushing.
        p_cur = 16'h0A00;
        m_cur = 16'h0B00;
        repeat (10) applyStimulus(1, 1, 0);
        checkOutput("bp_p_occ", P_occ, 4);
        checkOutput("bp_m_occ", M_occ, 4);
        checkOutput("bp_p_rdy", P_rdy, 0);
        checkOutput("bp_m_rdy", M_rdy, 0);
        checkOutput("bp_o_vld", O_vld, 1);
        head = {mq[0], pq[0]};
        checkOutput("bp_head", O_dat, head);
        base_beats = out_beats;
        repeat (6) applyStimulus(0, 0, 1);
        checkOutput("bp_drained", out_beats - base_beats, 4);
        checkOutput("bp_occ_zero", P_occ + M_occ, 0);

        // Framing with cfg_len = 3 over seven beats.
        cfg_len = 10'd3;
        base_last = last_seen;
        base_beats = out_beats;
        repeat (7) applyStimulus(1, 1, 1);
        repeat (2) applyStimulus(0, 0, 1);
        checkOutput("frm3_beats", out_beats - base_beats, 7);
        checkOutput("frm3_lasts", last_seen - base_last, 2);

        // Mid-frame reset with two beats buffered.
        repeat (2) applyStimulus(1, 1, 0);
        applyStimulus(0, 0, 0);
        checkOutput("mid_p_occ", P_occ, 2);
        checkOutput("mid_o_vld", O_vld, 1);
        cfg_len = 10'd2;
        doReset();
        base_beats = out_beats;
        repeat (2) applyStimulus(1, 1, 1);
        repeat (2) applyStimulus(0, 0, 1);
        checkOutput("post_rst_beats", out_beats - base_beats, 2);

        // cfg_len = 0 means a 1024-beat frame.
        cfg_len = '0;
        base_last = last_seen;
        base_beats = out_beats;
        repeat (1024) applyStimulus(1, 1, 1);
        repeat (2) applyStimulus(0, 0, 1);
        checkOutput("frm0_lasts", last_seen - base_last, 1);
        checkOutput("frm0_last_pos", last_beat_idx - base_beats, 1024);

        // Random valid/ready stalls against the scoreboard.
        cfg_len = 10'd5;
        rand_data = 1'b1;
        p_cur = 16'($urandom);
        m_cur = 16'($urandom);
        p_count = 0;
        m_count = 0;
        base_last = last_seen;
        base_beats = out_beats;
        for (int cyc = 0; cyc < 60000 && (out_beats - base_beats) < 10000; cyc++) begin
            applyStimulus((p_count < 10000) && ($urandom_range(1) == 1),
                          (m_count < 10000) && ($urandom_range(1) == 1),
                          $urandom_range(1) == 1);
        end
        checkOutput("rand_beats", out_beats - base_beats, 10000);
        checkOutput("rand_lasts", last_seen - base_last, 2000);
        checkOutput("rand_sb_empty", pq.size() + mq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
